dec138_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one 3-to-8 decoded select bus among eight requesters. It turns level requests into a registered 3-bit index plus enable that drive the `a` and `ON` inputs of the 138-style decoder. Grants are break-before-make: a one-cycle dead gap always separates two owners. A hold-time limit stops one requester from monopolising the bus under contention.

---
 rtl/dec138_rr_arbiter_pkg.sv | 14 +
 rtl/dec138_rr_arbiter_if.sv | 14 +
 rtl/dec138_rr_arbiter_rr_pick.sv | 32 +++
 rtl/dec138_rr_arbiter.sv | 118 +++++++++++
 tb/tb_dec138_rr_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dec138_rr_arbiter_pkg.sv
// Shared constants and state encoding for the decoded-select round-robin arbiter.
package dec138_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dec138_rr_arbiter_if.sv
// Request/select bundle between the requesters and the arbiter driving the 138 decoder.
interface dec138_rr_arbiter_if;
    import dec138_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] sel;
    logic             sel_on;
    logic [N_REQ-1:0] grant;
    logic             busy;

    modport master (output req, input sel, input sel_on, input grant, input busy);
    modport slave  (input req, output sel, output sel_on, output grant, output busy);

endinterface

// File: rtl/dec138_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first requester above the last owner, wrapping.
// With ARB_PRIO0_EN defined, requester 0 overrides the rotation whenever it requests.
module rr_pick
    import dec138_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        // Walk from farthest to nearest so the nearest hit after last wins.
        for (int i = int'(N_REQ); i >= 1; i--) begin
            cand = last + IDX_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
`ifdef ARB_PRIO0_EN
        if (req[0]) begin
            idx = '0;
        end
`endif
    end

endmodule

// File: rtl/dec138_rr_arbiter.sv
// Break-before-make round-robin arbiter feeding a 3-to-8 decoder (a/ON) with a hold limit.
// Optional ARB_PRIO0_EN: requester 0 has absolute priority and is never force-released.
module dec138_rr_arbiter
    import dec138_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input logic                clk,
    input logic                rst_n,
    dec138_rr_arbiter_if.slave bus
);

    localparam logic [1:0] StIdle  = IDLE;
    localparam logic [1:0] StGrant = GRANT;
    localparam logic [1:0] StGap   = GAP;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             sel_on_q, sel_on_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [CNT_W:0]   cnt_next;
    logic             others;
    logic             hold_hit;
    logic             exempt;

    rr_pick u_pick (
        .req  (bus.req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        cnt_next = {1'b0, cnt_q} + 1'b1;
        others   = |(bus.req & ~(N_REQ'(1) << sel_q));
        hold_hit = (HOLD_MAX != 0) && (cnt_next >= (CNT_W + 1)'(HOLD_MAX));
`ifdef ARB_PRIO0_EN
        exempt   = (sel_q == '0);
`else
        exempt   = 1'b0;
`endif

        state_d  = state_q;
        sel_d    = sel_q;
        sel_on_d = sel_on_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        last_d   = last_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle, StGap: begin
                if (pick_any) begin
                    state_d  = StGrant;
                    sel_d    = pick_idx;
                    sel_on_d = 1'b1;
                    grant_d  = N_REQ'(1) << pick_idx;
                    busy_d   = 1'b1;
                    last_d   = pick_idx;
                    cnt_d    = '0;
                end else begin
                    state_d  = StIdle;
                    sel_on_d = 1'b0;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                end
            end
            StGrant: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_next[CNT_W-1:0];
                // sel is held through the gap so the decoder address never moves while ON=1.
                if (!bus.req[sel_q] || (hold_hit && others && !exempt)) begin
                    state_d  = StGap;
                    sel_on_d = 1'b0;
                    grant_d  = '0;
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                sel_on_d = 1'b0;
                grant_d  = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            sel_on_q <= 1'b0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            last_q   <= IDX_W'(N_REQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_on_q <= sel_on_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.sel_on = sel_on_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_dec138_rr_arbiter.sv
// Randomised and directed bench for dec138_rr_arbiter against an owner/hold-count model.
module tb_dec138_rr_arbiter;
    import dec138_arb_pkg::*;

    localparam int unsigned HOLD = 4;
`ifdef ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dec138_rr_arbiter_if bus ();

    dec138_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: who owns the bus, whether a gap is pending, how many grant cycles elapsed.
    int         m_sel  = 0;
    bit         m_on   = 1'b0;
    bit         m_gap  = 1'b0;
    int         m_last = 7;
    int         m_held = 0;
    int         m_pick;
    logic [7:0] m_req;
    bit         m_other;

    function automatic int pick(input logic [7:0] r, input int last);
        if (PRIO0 && r[0]) return 0;
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        m_req = bus.req;
        if (!rst_n) begin
            m_sel  = 0;
            m_on   = 1'b0;
            m_gap  = 1'b0;
            m_last = 7;
            m_held = 0;
        end else if (m_on) begin
            m_held++;
            m_other = (m_req & ~(8'd1 << m_sel)) != 8'd0;
            if (!m_req[m_sel] ||
                (m_held >= int'(HOLD) && m_other && !(PRIO0 && m_sel == 0))) begin
                m_on  = 1'b0;
                m_gap = 1'b1;
            end
        end else begin
            m_gap  = 1'b0;
            m_pick = pick(m_req, m_last);
            if (m_pick >= 0) begin
                m_on   = 1'b1;
                m_sel  = m_pick;
                m_last = m_pick;
                m_held = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sel",    32'(bus.sel), 32'(m_sel));
            check("sel_on", 32'(bus.sel_on), 32'(m_on));
            check("grant",  32'(bus.grant), m_on ? (32'd1 << m_sel) : 32'd0);
            check("busy",   32'(bus.busy), 32'(m_on || m_gap));
            check("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req = 8'h00;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_sel_on", 32'(bus.sel_on), 32'd0);
        check("rst_grant",  32'(bus.grant), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_sel",    32'(bus.sel), 32'd0);

        // Single request: one-cycle latency.
        rst_n   = 1'b1;
        bus.req = 8'h04;
        @(negedge clk);
        check("first_sel",    32'(bus.sel), 32'd2);
        check("first_sel_on", 32'(bus.sel_on), 32'd1);
        check("first_grant",  32'(bus.grant), 32'h04);
        check("first_busy",   32'(bus.busy), 32'd1);

        // Full contention: HOLD-cycle tenures separated by one gap.
        bus.req = 8'hFF;
        do_reset();
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (PRIO0) begin
                check("rot_sel",    32'(bus.sel), 32'd0);
                check("rot_sel_on", 32'(bus.sel_on), 32'd1);
            end else begin
                check("rot_sel",    32'(bus.sel), 32'((k / 5) % 8));
                check("rot_sel_on", 32'(bus.sel_on), 32'((k % 5) < 4));
            end
        end

        // Uncontended owner past counter saturation, then contention forces release.
        bus.req = 8'h08;
        do_reset();
        repeat (300) @(negedge clk);
        check("solo_sel",    32'(bus.sel), 32'd3);
        check("solo_sel_on", 32'(bus.sel_on), 32'd1);
        bus.req = 8'h28;
        @(negedge clk);
        check("force_gap_on",   32'(bus.sel_on), 32'd0);
        check("force_gap_busy", 32'(bus.busy), 32'd1);
        check("force_gap_sel",  32'(bus.sel), 32'd3);
        @(negedge clk);
        check("force_next_sel",   32'(bus.sel), 32'd5);
        check("force_next_grant", 32'(bus.grant), 32'h20);

        // Voluntary release with wrap 6 -> 1.
        bus.req = 8'h40;
        do_reset();
        @(negedge clk);
        check("wrap_own6", 32'(bus.sel), 32'd6);
        bus.req = 8'h02;
        @(negedge clk);
        check("wrap_gap", 32'(bus.sel_on), 32'd0);
        @(negedge clk);
        check("wrap_sel1", 32'(bus.sel), 32'd1);
        check("wrap_on",   32'(bus.sel_on), 32'd1);

        // Reset during a grant: no gap, pointer back to 7.
        bus.req = 8'h10;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        check("mid_own4", 32'(bus.sel), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_on",    32'(bus.sel_on), 32'd0);
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_busy",  32'(bus.busy), 32'd0);
        rst_n   = 1'b1;
        bus.req = 8'h11;
        @(negedge clk);
        check("mid_regrant0", 32'(bus.sel), 32'd0);

        // Pointer at 6, requesters 0 and 7 contend.
        bus.req = 8'h40;
        do_reset();
        @(negedge clk);
        bus.req = 8'h81;
        @(negedge clk);
        @(negedge clk);
        check("p81_sel", 32'(bus.sel), PRIO0 ? 32'd0 : 32'd7);
        repeat (100) @(negedge clk);
        if (PRIO0) check("p0_exempt", 32'(bus.sel), 32'd0);

        // Random traffic with occasional resets.
        bus.req = 8'h00;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 15) == 0) bus.req[b] = ~bus.req[b];
            end
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
